// File: rtl/xdma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xdma_pkg
// Description : Shared xDMA grant-manager types and constants.
// Revision    : 1.0
// ============================================================================
package xdma_pkg;

  localparam int unsigned c_addr_w = 32;

  localparam logic [c_addr_w-1:0] ClusterXDMAGRANTMMIOOffset = 32'h0002_0000;

  typedef struct packed {
    logic [7:0]          dma_id;
    logic [19:0]         dma_length;
    logic [1:0]          dma_type;
    logic [c_addr_w-1:0] src_addr;
    logic                ready_to_transfer;
  } xdma_from_remote_data_accompany_cfg_t;

  typedef struct packed {
    logic [7:0]          dma_id;
    logic [c_addr_w-1:0] from;
    logic [23:0]         reserved;
  } xdma_to_remote_grant_t;

  typedef struct packed {
    logic [7:0]          dma_id;
    logic [19:0]         dma_length;
    logic [1:0]          dma_type;
    logic [c_addr_w-1:0] remote_addr;
    logic                ready_to_transfer;
  } xdma_req_desc_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PENDING     = 2'd1,
    QUEUED      = 2'd2,
    WAIT_FINISH = 2'd3
  } xdma_chan_state_e;

endpackage
`default_nettype wire

// File: rtl/xdma_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xdma_rr_arbiter
// Description : Round-robin arbiter; pointer moves past the winner on advance.
// Revision    : 1.0
// ============================================================================
module xdma_rr_arbiter #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned IdxWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] req_i,
  input  logic                   advance_i,
  output logic [NumChannels-1:0] gnt_o,
  output logic [IdxWidth-1:0]    idx_o,
  output logic                   valid_o
);

  logic [IdxWidth-1:0] r_ptr;
  logic [IdxWidth-1:0] w_pos;

  // Scan from the pointer upwards; the first requester found wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      w_pos = IdxWidth'((32'(r_ptr) + i) % NumChannels);
      if (!valid_o && req_i[w_pos]) begin
        gnt_o[w_pos] = 1'b1;
        idx_o        = w_pos;
        valid_o      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (advance_i && valid_o) begin
      r_ptr <= (idx_o == IdxWidth'(NumChannels - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xdma_grant_manager_mc.sv
`default_nettype none
// ============================================================================
// Module      : xdma_grant_manager_mc
// Description : Multi-channel grant manager with a registered round-robin slot.
// Revision    : 1.0
// ============================================================================
module xdma_grant_manager_mc
  import xdma_pkg::*;
#(
  parameter int unsigned          NumChannels     = 4,
  parameter int unsigned          ChanIdxWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  parameter int unsigned          CntWidth        = 16,
  parameter logic [c_addr_w-1:0]  GrantMmioOffset = ClusterXDMAGRANTMMIOOffset
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  xdma_from_remote_data_accompany_cfg_t [NumChannels-1:0] cfg_i,
  output xdma_req_desc_t                                        grant_desc_o,
  output xdma_to_remote_grant_t                                 grant_o,
  output logic [ChanIdxWidth-1:0]                               grant_chan_o,
  output logic                                                  grant_valid_o,
  input  logic                                                  grant_ready_i,
  output logic [NumChannels-1:0]                                chan_busy_o,
  output logic [CntWidth-1:0]                                   grant_cnt_o
);

  xdma_chan_state_e                     r_state [NumChannels];
  logic [NumChannels-1:0]               w_rtt;
  logic [NumChannels-1:0]               w_req;
  logic [NumChannels-1:0]               w_win;
  logic [ChanIdxWidth-1:0]              w_win_idx;
  logic                                 w_win_valid;
  logic                                 w_load;
  logic                                 w_hs;
  xdma_from_remote_data_accompany_cfg_t w_sel;

  assign w_hs   = grant_valid_o && grant_ready_i;
  assign w_load = !grant_valid_o || grant_ready_i;
  assign w_sel  = cfg_i[w_win_idx];

  xdma_rr_arbiter #(
    .NumChannels (NumChannels),
    .IdxWidth    (ChanIdxWidth)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (w_req),
    .advance_i (w_load),
    .gnt_o     (w_win),
    .idx_o     (w_win_idx),
    .valid_o   (w_win_valid)
  );

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    xdma_chan_state_e w_state_nxt;

    assign w_rtt[c]       = cfg_i[c].ready_to_transfer;
    // A revoked channel must not win, so rtt gates the request directly.
    assign w_req[c]       = (r_state[c] == PENDING) && w_rtt[c];
    assign chan_busy_o[c] = (r_state[c] != IDLE);

    always_comb begin
      w_state_nxt = r_state[c];
      unique case (r_state[c])
        IDLE:        if (w_rtt[c]) w_state_nxt = PENDING;
        PENDING: begin
          if (!w_rtt[c])             w_state_nxt = IDLE;
          else if (w_load && w_win[c]) w_state_nxt = QUEUED;
        end
        // Only the slot owner can be QUEUED, so any handshake is its own.
        QUEUED:      if (w_hs) w_state_nxt = WAIT_FINISH;
        WAIT_FINISH: if (!w_rtt[c]) w_state_nxt = IDLE;
        default:     w_state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state[c] <= IDLE;
      else       r_state[c] <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_valid_o <= 1'b0;
      grant_desc_o  <= '0;
      grant_o       <= '0;
      grant_chan_o  <= '0;
    end else if (w_load) begin
      grant_valid_o <= w_win_valid;
      if (w_win_valid) begin
        grant_chan_o                   <= w_win_idx;
        grant_desc_o.dma_id            <= w_sel.dma_id;
        grant_desc_o.dma_length        <= w_sel.dma_length;
        grant_desc_o.dma_type          <= w_sel.dma_type;
        grant_desc_o.remote_addr       <= w_sel.src_addr + GrantMmioOffset;
        grant_desc_o.ready_to_transfer <= 1'b1;
        grant_o.dma_id                 <= w_sel.dma_id;
        grant_o.from                   <= w_sel.src_addr;
        grant_o.reserved               <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_o <= '0;
    end else if (w_hs && (grant_cnt_o != '1)) begin
      grant_cnt_o <= grant_cnt_o + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xdma_grant_manager_mc.sv
`default_nettype none
// Randomized bench for xdma_grant_manager_mc against a flag-based reference model.
module tb_xdma_grant_manager_mc;
  import xdma_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic ready;
  xdma_from_remote_data_accompany_cfg_t [N-1:0] cfg;

  xdma_req_desc_t        desc, desc4;
  xdma_to_remote_grant_t gnt, gnt4;
  logic [1:0]            chan, chan4;
  logic                  valid, valid4;
  logic [N-1:0]          busy, busy4;
  logic [15:0]           cnt;
  logic [3:0]            cnt4;

  always #5 clk = ~clk;

  xdma_grant_manager_mc #(.NumChannels(N), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg), .grant_desc_o(desc), .grant_o(gnt),
    .grant_chan_o(chan), .grant_valid_o(valid), .grant_ready_i(ready),
    .chan_busy_o(busy), .grant_cnt_o(cnt));

  xdma_grant_manager_mc #(.NumChannels(N), .CntWidth(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg), .grant_desc_o(desc4), .grant_o(gnt4),
    .grant_chan_o(chan4), .grant_valid_o(valid4), .grant_ready_i(ready),
    .chan_busy_o(busy4), .grant_cnt_o(cnt4));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: armed = waiting to be picked, spent = delivered but rtt still high.
  bit armed [N];
  bit spent [N];
  bit m_valid;
  int m_chan;
  int m_ptr;
  int m_cnt;
  xdma_from_remote_data_accompany_cfg_t m_cfg;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      armed[c] = 0;
      spent[c] = 0;
    end
    m_valid = 0; m_chan = 0; m_ptr = 0; m_cnt = 0; m_cfg = '0;
  endtask

  task automatic model_step();
    bit hs, load, rtt, owner, idle;
    int win, c;
    bit n_armed [N];
    bit n_spent [N];
    hs   = m_valid && ready;
    load = !m_valid || ready;
    win  = -1;
    if (load)
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (win < 0 && armed[c] && cfg[c].ready_to_transfer) win = c;
      end
    for (int j = 0; j < N; j++) begin
      rtt        = cfg[j].ready_to_transfer;
      owner      = m_valid && (m_chan == j);
      idle       = !armed[j] && !spent[j] && !owner;
      n_armed[j] = rtt && ((armed[j] && win != j) || idle);
      n_spent[j] = (spent[j] && rtt) || (hs && owner);
    end
    for (int j = 0; j < N; j++) begin
      armed[j] = n_armed[j];
      spent[j] = n_spent[j];
    end
    if (hs && m_cnt < 65535) m_cnt++;
    if (load) begin
      if (win >= 0) begin
        m_valid = 1; m_chan = win; m_cfg = cfg[win]; m_ptr = (win + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  exp_busy;
    logic [31:0]   exp_raddr;
    for (int c = 0; c < N; c++)
      exp_busy[c] = armed[c] || spent[c] || (m_valid && m_chan == c);
    chk("valid", valid, m_valid);
    chk("busy", busy, exp_busy);
    chk("cnt", cnt, m_cnt);
    chk("cnt_sat4", cnt4, (m_cnt > 15) ? 15 : m_cnt);
    if (m_valid) begin
      exp_raddr = m_cfg.src_addr + 32'h0002_0000;
      chk("chan", chan, m_chan);
      chk("desc_id", desc.dma_id, m_cfg.dma_id);
      chk("desc_len", desc.dma_length, m_cfg.dma_length);
      chk("desc_type", desc.dma_type, m_cfg.dma_type);
      chk("desc_raddr", desc.remote_addr, exp_raddr);
      chk("desc_rtt", desc.ready_to_transfer, 1);
      chk("grant_id", gnt.dma_id, m_cfg.dma_id);
      chk("grant_from", gnt.from, m_cfg.src_addr);
      chk("grant_rsvd", gnt.reserved, 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_ch(input int c, input bit rtt, input logic [31:0] src, input logic [7:0] id);
    cfg[c].ready_to_transfer = rtt;
    cfg[c].src_addr          = src;
    cfg[c].dma_id            = id;
    cfg[c].dma_length        = 20'(id * 16);
    cfg[c].dma_type          = 2'(c);
  endtask

  task automatic drive_rand();
    for (int c = 0; c < N; c++) begin
      if ($urandom_range(0, 3) == 0) cfg[c].ready_to_transfer = ~cfg[c].ready_to_transfer;
      cfg[c].dma_id     = 8'($urandom);
      cfg[c].dma_length = 20'($urandom);
      cfg[c].dma_type   = 2'($urandom);
      cfg[c].src_addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 + 32'($urandom_range(0, 65535))
                                                      : 32'($urandom);
    end
    ready = ($urandom_range(0, 9) < 7);
  endtask

  bit did_rst = 0;

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    cfg   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chan", chan, 0);
    chk("rst_desc", desc, 0);
    chk("rst_grant", gnt, 0);
    rst = 1'b0;

    // Single channel, then all four together, then a pair.
    ready = 1'b1;
    set_ch(0, 1, 32'h1000_0000, 8'd5);
    run(5);
    set_ch(0, 0, 32'h1000_0000, 8'd5);
    run(2);
    for (int c = 0; c < N; c++) set_ch(c, 1, 32'h2000_0000 + 32'(c), 8'(10 + c));
    run(7);
    for (int c = 0; c < N; c++) cfg[c].ready_to_transfer = 1'b0;
    run(2);
    set_ch(1, 1, 32'h3000_0000, 8'd21);
    set_ch(3, 1, 32'h3000_0300, 8'd23);
    run(4);
    for (int c = 0; c < N; c++) cfg[c].ready_to_transfer = 1'b0;
    run(2);

    // Backpressure with the presented channel revoking while held.
    ready = 1'b0;
    set_ch(2, 1, 32'h4000_0000, 8'd42);
    run(3);
    cfg[2].ready_to_transfer = 1'b0;
    run(3);
    ready = 1'b1;
    run(3);

    // Short revocation pulse while the slot is blocked.
    ready = 1'b0;
    set_ch(0, 1, 32'h5000_0000, 8'd50);
    run(3);
    set_ch(1, 1, 32'h5100_0000, 8'd51);
    run(1);
    cfg[1].ready_to_transfer = 1'b0;
    run(2);
    ready = 1'b1;
    run(3);
    cfg[0].ready_to_transfer = 1'b0;
    run(2);

    for (int i = 0; i < 800; i++) begin
      drive_rand();
      cycle();
      if (!did_rst && i >= 200 && m_valid) begin
        did_rst = 1;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", valid, 0);
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
